// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_if
// Description : Control/status bundle for countdown_timer.
//               Controls (driven by master): load, load_val[7:0] (BCD),
//               start, pause.
//               Status (driven by slave): tens[3:0], ones[3:0] (BCD),
//               busy, done.
// Revision    : 1.0  initial release
// ============================================================================
interface countdown_timer_if;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;

    modport master (
        output load, load_val, start, pause,
        input  tens, ones, busy, done
    );

    modport slave (
        input  load, load_val, start, pause,
        output tens, ones, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Two-digit BCD down-counter (00-99) with load/start/pause.
//               Steps once every CLK_DIV clocks while running and pulses
//               done for one cycle when the count reaches 00.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - countdown_timer_if.slave (load, load_val, start,
//                        pause in; tens, ones, busy, done out; all outputs
//                        registered)
// Parameters  : CLK_DIV - clocks per count step, 1..65536
// Revision    : 1.0  initial release
// ============================================================================
module countdown_timer #(
    parameter int CLK_DIV = 1
) (
    input  wire               clk,
    input  wire               rst_n,
    countdown_timer_if.slave  bus
);

    localparam int             PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    tens_q,  tens_d;
    logic [3:0]    ones_q,  ones_d;
    logic [PW-1:0] pre_q,   pre_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic          w_nonzero;
    logic          w_step_due;
    logic          w_terminal;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign w_nonzero  = (tens_q != 4'd0) || (ones_q != 4'd0);
    assign w_step_due = (state_q == ST_RUN) && !bus.pause && (pre_q == PRE_MAX);
    // Only 01 steps to 00: a zero ones digit borrows to 9, never to 0.
    assign w_terminal = w_step_due && (tens_q == 4'd0) && (ones_q == 4'd1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            pre_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            pre_q   <= pre_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (bus.start && w_nonzero) state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.pause)       state_d = ST_PAUSE;
                    else if (w_terminal) state_d = ST_IDLE;
                end
                // start beats a simultaneous pause
                ST_PAUSE: if (bus.start) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath / registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        pre_d  = pre_q;
        done_d = 1'b0;
        if (bus.load) begin
            tens_d = clamp9(bus.load_val[7:4]);
            ones_d = clamp9(bus.load_val[3:0]);
            pre_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && w_nonzero) pre_d = '0;
                end
                ST_RUN: begin
                    // A pause edge freezes everything, even a due step.
                    if (!bus.pause) begin
                        if (w_step_due) begin
                            pre_d = '0;
                            if (ones_q != 4'd0) begin
                                ones_d = ones_q - 4'd1;
                            end else begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end
                            done_d = w_terminal;
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    assign bus.tens = tens_q;
    assign bus.ones = ones_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire
